// File: rtl/regfile_sched_if.sv
// regfile_sched_if: bundles the write-request, issue, query and
// register-file write signals of the write-port scheduler.
//   master - the side driving requests/issues/queries (decode, ALU, LSU)
//   slave  - the scheduler itself
interface regfile_sched_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_reg;
  logic [31:0] a_data;

  logic        l_valid;
  logic        l_ready;
  logic [4:0]  l_reg;
  logic [31:0] l_data;

  logic        iss_valid;
  logic [4:0]  iss_reg;
  logic        iss_ready;

  logic [4:0]  q1_reg;
  logic [4:0]  q2_reg;
  logic        q1_hazard;
  logic        q2_hazard;
  logic        q1_fwd;
  logic        q2_fwd;
  logic [31:0] q1_data;
  logic [31:0] q2_data;

  logic [4:0]  rwr;
  logic [31:0] wr;
  logic        wren;

  modport master (
    output a_valid, a_reg, a_data,
    output l_valid, l_reg, l_data,
    output iss_valid, iss_reg,
    output q1_reg, q2_reg,
    input  a_ready, l_ready, iss_ready,
    input  q1_hazard, q2_hazard, q1_fwd, q2_fwd, q1_data, q2_data,
    input  rwr, wr, wren
  );

  modport slave (
    input  a_valid, a_reg, a_data,
    input  l_valid, l_reg, l_data,
    input  iss_valid, iss_reg,
    input  q1_reg, q2_reg,
    output a_ready, l_ready, iss_ready,
    output q1_hazard, q2_hazard, q1_fwd, q2_fwd, q1_data, q2_data,
    output rwr, wr, wren
  );
endinterface

// File: rtl/regfile_sched.sv
// regfile_sched: write-port scheduler and RAW/WAW hazard scoreboard for the
// 31x32 register file (r0 is hardwired zero and never written).
//
// ALU and LSU writebacks share the single write port. A round-robin pointer
// settles contention (LSU first out of reset). The granted write goes through
// an output stage (drives rwr/wr/wren) and then a pending stage, which
// covers the cycle in which the file commits the write. The busy bit of the
// destination clears when the write leaves the pending stage.
//
// Build option: define REGFILE_SCHED_BYPASS_EN to forward data from the
// output and pending stages to the decode queries instead of stalling.
module regfile_sched (
  input  logic             clock,
  input  logic             reset_n,
  regfile_sched_if.slave   bus
);

  // Round-robin pointer: 0 = LSU wins the next contested cycle.
  logic        rr_ptr;
  logic        contested;
  logic        a_grant;
  logic        l_grant;
  logic        any_grant;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;

  logic        out_vld;
  logic [4:0]  out_reg;
  logic [31:0] out_data;

  logic        pend_vld;
  logic [4:0]  pend_reg;
  logic [31:0] pend_data;

  logic [31:1] busy;
  logic [31:0] busy_ext;
  logic [31:1] busy_set;
  logic [31:1] busy_clr;
  logic        iss_ok;

  logic        q1_fwd;
  logic        q2_fwd;
  logic [31:0] q1_data;
  logic [31:0] q2_data;

  // r0 has no busy bit; a zero in slot 0 keeps every r0 query clean.
  assign busy_ext = {busy, 1'b0};

  // Combinational grant; readies are forced low while reset is asserted.
  always_comb begin
    contested = bus.a_valid & bus.l_valid;
    a_grant   = reset_n & bus.a_valid & (~bus.l_valid | rr_ptr);
    l_grant   = reset_n & bus.l_valid & (~bus.a_valid | ~rr_ptr);
    any_grant = a_grant | l_grant;
    sel_reg   = l_grant ? bus.l_reg  : bus.a_reg;
    sel_data  = l_grant ? bus.l_data : bus.a_data;
  end

  assign bus.a_ready = a_grant;
  assign bus.l_ready = l_grant;

  // Pointer flips only after a contested grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= 1'b0;
    end else if (contested) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  // Output stage: the file captures rwr/wr when wren is high. Writes to r0
  // are accepted but never raise wren.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_vld  <= 1'b0;
      out_reg  <= 5'd0;
      out_data <= 32'd0;
    end else begin
      out_vld <= any_grant && (sel_reg != 5'd0);
      if (any_grant) begin
        out_reg  <= sel_reg;
        out_data <= sel_data;
      end
    end
  end

  assign bus.rwr  = out_reg;
  assign bus.wr   = out_data;
  assign bus.wren = out_vld;

  // Pending stage: the write the file is committing this cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld  <= 1'b0;
      pend_reg  <= 5'd0;
      pend_data <= 32'd0;
    end else begin
      pend_vld  <= out_vld;
      pend_reg  <= out_reg;
      pend_data <= out_data;
    end
  end

  assign iss_ok        = ~busy_ext[bus.iss_reg];
  assign bus.iss_ready = iss_ok;

  // Scoreboard set/clear vectors. A new issue wins over a retiring write to
  // the same register, since that write belongs to an older producer.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    for (int i = 1; i < 32; i++) begin
      if (bus.iss_valid && iss_ok && (bus.iss_reg == 5'(i))) begin
        busy_set[i] = 1'b1;
      end
      if (pend_vld && (pend_reg == 5'(i))) begin
        busy_clr[i] = 1'b1;
      end
    end
  end

  // Busy bits update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~busy_clr) | busy_set;
    end
  end

`ifdef REGFILE_SCHED_BYPASS_EN
  // Bypass select: the output stage holds the younger value, so it wins.
  always_comb begin
    q1_fwd  = 1'b0;
    q1_data = 32'd0;
    q2_fwd  = 1'b0;
    q2_data = 32'd0;
    if (busy_ext[bus.q1_reg] && out_vld && (out_reg == bus.q1_reg)) begin
      q1_fwd  = 1'b1;
      q1_data = out_data;
    end else if (busy_ext[bus.q1_reg] && pend_vld && (pend_reg == bus.q1_reg)) begin
      q1_fwd  = 1'b1;
      q1_data = pend_data;
    end
    if (busy_ext[bus.q2_reg] && out_vld && (out_reg == bus.q2_reg)) begin
      q2_fwd  = 1'b1;
      q2_data = out_data;
    end else if (busy_ext[bus.q2_reg] && pend_vld && (pend_reg == bus.q2_reg)) begin
      q2_fwd  = 1'b1;
      q2_data = pend_data;
    end
  end
`else
  assign q1_fwd  = 1'b0;
  assign q2_fwd  = 1'b0;
  assign q1_data = 32'd0;
  assign q2_data = 32'd0;
`endif

  assign bus.q1_fwd    = q1_fwd;
  assign bus.q2_fwd    = q2_fwd;
  assign bus.q1_data   = q1_data;
  assign bus.q2_data   = q2_data;
  assign bus.q1_hazard = busy_ext[bus.q1_reg] && (bus.q1_reg != 5'd0) && !q1_fwd;
  assign bus.q2_hazard = busy_ext[bus.q2_reg] && (bus.q2_reg != 5'd0) && !q2_fwd;

endmodule
